// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues credit-limited word fetches and
// buffers in-order responses in a prefetch queue presented to decode.
module fetch_unit #(
    parameter int              XLEN     = 32,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            reset,
    output logic            IFreq_valid,
    output logic [XLEN-1:0] IFreq_addr,
    input  logic            IFreq_ready,
    input  logic            IFrsp_valid,
    input  logic [XLEN-1:0] IFrsp_data,
    output logic            IFinstr_valid,
    output logic [XLEN-1:0] IFinstr,
    output logic [XLEN-1:0] IFpc,
    input  logic            IFinstr_ready,
    input  logic            IFredirect,
    input  logic [XLEN-1:0] IFredirect_pc
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [0:0] {FETCH, DRAIN} state_t;

    state_t          state, state_next;
    logic            started;
    logic [XLEN-1:0] fetch_pc;
    logic [CW-1:0]   outstanding, outstanding_next;
    logic [CW-1:0]   q_cnt, q_cnt_next;
    logic [CW:0]     credit_used;
    logic [AW-1:0]   inf_wr, inf_rd, q_wr, q_rd;
    logic [XLEN-1:0] inf_pc  [DEPTH];
    logic [XLEN-1:0] q_instr [DEPTH];
    logic [XLEN-1:0] q_pc    [DEPTH];
    logic            req_fire, rsp_take, push, pop;

    function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

    // Queue slots plus in-flight requests never exceed DEPTH, so responses need no backpressure.
    assign credit_used   = {1'b0, q_cnt} + {1'b0, outstanding};
    assign IFreq_valid   = started && (state == FETCH) && (credit_used < (CW+1)'(DEPTH));
    assign IFreq_addr    = fetch_pc;
    assign req_fire      = IFreq_valid && IFreq_ready;
    assign rsp_take      = IFrsp_valid && (outstanding != '0);
    assign push          = rsp_take && (state == FETCH) && !IFredirect;
    assign IFinstr_valid = (q_cnt != '0);
    assign pop           = IFinstr_valid && IFinstr_ready && !IFredirect;
    assign IFinstr       = IFinstr_valid ? q_instr[q_rd] : '0;
    assign IFpc          = IFinstr_valid ? q_pc[q_rd]    : '0;

    assign outstanding_next = outstanding + CW'(req_fire) - CW'(rsp_take);

    always_comb begin
        state_next = state;
        q_cnt_next = q_cnt + CW'(push) - CW'(pop);
        if (IFredirect) begin
            q_cnt_next = '0;
        end
        // A redirect with fetches still in flight must swallow their stale responses.
        if (IFredirect || (state == DRAIN)) begin
            state_next = (outstanding_next == '0) ? FETCH : DRAIN;
        end
    end

    // Stage boundary: control state
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= FETCH;
            started     <= 1'b0;
            fetch_pc    <= RESET_PC;
            outstanding <= '0;
            q_cnt       <= '0;
            inf_wr      <= '0;
            inf_rd      <= '0;
            q_wr        <= '0;
            q_rd        <= '0;
        end else begin
            state       <= state_next;
            started     <= 1'b1;
            outstanding <= outstanding_next;
            q_cnt       <= q_cnt_next;
            if (IFredirect) begin
                fetch_pc <= align_word(IFredirect_pc);
            end else if (req_fire) begin
                fetch_pc <= fetch_pc + XLEN'(4);
            end
            if (req_fire) inf_wr <= inf_wr + AW'(1);
            if (rsp_take) inf_rd <= inf_rd + AW'(1);
            if (IFredirect) begin
                q_wr <= '0;
                q_rd <= '0;
            end else begin
                if (push) q_wr <= q_wr + AW'(1);
                if (pop)  q_rd <= q_rd + AW'(1);
            end
        end
    end

    // Stage boundary: in-flight PC tags and prefetch queue storage
    always_ff @(posedge clk) begin
        if (req_fire) begin
            inf_pc[inf_wr] <= fetch_pc;
        end
        if (push) begin
            q_instr[q_wr] <= IFrsp_data;
            q_pc[q_wr]    <= inf_pc[inf_rd];
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a 1-cycle in-order memory model driven from tick().
module tb_fetch_unit;
    logic        clk;
    logic        reset;
    logic        IFreq_valid;
    logic [31:0] IFreq_addr;
    logic        IFreq_ready;
    logic        IFrsp_valid;
    logic [31:0] IFrsp_data;
    logic        IFinstr_valid;
    logic [31:0] IFinstr;
    logic [31:0] IFpc;
    logic        IFinstr_ready;
    logic        IFredirect;
    logic [31:0] IFredirect_pc;

    int pass_cnt = 0;
    int chk_cnt  = 0;
    logic        mem_en;
    logic [31:0] pend[$];
    logic [31:0] fire_addr[$];
    logic [31:0] got_pc[$];
    logic [31:0] got_ins[$];

    fetch_unit #(.XLEN(32), .DEPTH(4), .RESET_PC(32'h0)) dut (
        .clk(clk), .reset(reset),
        .IFreq_valid(IFreq_valid), .IFreq_addr(IFreq_addr), .IFreq_ready(IFreq_ready),
        .IFrsp_valid(IFrsp_valid), .IFrsp_data(IFrsp_data),
        .IFinstr_valid(IFinstr_valid), .IFinstr(IFinstr), .IFpc(IFpc),
        .IFinstr_ready(IFinstr_ready),
        .IFredirect(IFredirect), .IFredirect_pc(IFredirect_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One clock: record handshakes seen this cycle, advance, then drive the memory response.
    task automatic tick();
        logic        f, p;
        logic [31:0] a;
        f = IFreq_valid && IFreq_ready;
        a = IFreq_addr;
        p = IFinstr_valid && IFinstr_ready && !IFredirect && !reset;
        if (p) begin
            got_pc.push_back(IFpc);
            got_ins.push_back(IFinstr);
        end
        if (f) fire_addr.push_back(a);
        @(posedge clk);
        #1;
        if (f) pend.push_back(a);
        if (mem_en && pend.size() > 0) begin
            IFrsp_valid = 1'b1;
            IFrsp_data  = pend.pop_front() >> 2;
        end else begin
            IFrsp_valid = 1'b0;
            IFrsp_data  = 32'h0;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1; mem_en = 1'b0; IFreq_ready = 1'b0; IFinstr_ready = 1'b0;
        IFredirect = 1'b0; IFredirect_pc = 32'h0;
        tick();
        tick();
        pend.delete(); fire_addr.delete(); got_pc.delete(); got_ins.delete();
        IFrsp_valid = 1'b0; IFrsp_data = 32'h0;
        reset = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b1; mem_en = 1'b0; IFreq_ready = 1'b0; IFinstr_ready = 1'b0;
        IFredirect = 1'b0; IFredirect_pc = 32'h0; IFrsp_valid = 1'b0; IFrsp_data = 32'h0;
        tick();
        tick();
        chk_cnt++; if (IFreq_valid !== 1'b0) $display("FAIL reset_req_valid: got %0b want 0", IFreq_valid); else pass_cnt++;
        chk_cnt++; if (IFreq_addr !== 32'h0) $display("FAIL reset_req_addr: got %h want 0", IFreq_addr); else pass_cnt++;
        chk_cnt++; if (IFinstr_valid !== 1'b0) $display("FAIL reset_instr_valid: got %0b want 0", IFinstr_valid); else pass_cnt++;
        chk_cnt++; if (IFinstr !== 32'h0) $display("FAIL reset_instr: got %h want 0", IFinstr); else pass_cnt++;
        chk_cnt++; if (IFpc !== 32'h0) $display("FAIL reset_pc: got %h want 0", IFpc); else pass_cnt++;
        reset = 1'b0;
        chk_cnt++; if (IFreq_valid !== 1'b0) $display("FAIL reset_release_valid: got %0b want 0", IFreq_valid); else pass_cnt++;
        tick();
        chk_cnt++; if (IFreq_valid !== 1'b1) $display("FAIL reset_first_req: got %0b want 1", IFreq_valid); else pass_cnt++;
    endtask

    task automatic test_stream();
        do_reset();
        mem_en = 1'b1; IFreq_ready = 1'b1; IFinstr_ready = 1'b1;
        for (int i = 0; i < 8; i++) tick();
        chk_cnt++; if (fire_addr.size() !== 8) $display("FAIL stream_fires: got %0d want 8", fire_addr.size()); else pass_cnt++;
        chk_cnt++; if (got_pc.size() !== 6) $display("FAIL stream_pops: got %0d want 6", got_pc.size()); else pass_cnt++;
        for (int i = 0; i < 6 && i < got_pc.size(); i++) begin
            chk_cnt++; if (got_pc[i] !== 32'(4*i)) $display("FAIL stream_pc%0d: got %h want %h", i, got_pc[i], 32'(4*i)); else pass_cnt++;
            chk_cnt++; if (got_ins[i] !== 32'(i)) $display("FAIL stream_ins%0d: got %h want %h", i, got_ins[i], 32'(i)); else pass_cnt++;
        end
    endtask

    task automatic test_full();
        do_reset();
        mem_en = 1'b1; IFreq_ready = 1'b1; IFinstr_ready = 1'b0;
        for (int i = 0; i < 8; i++) tick();
        chk_cnt++; if (fire_addr.size() !== 4) $display("FAIL full_fires: got %0d want 4", fire_addr.size()); else pass_cnt++;
        chk_cnt++; if (IFreq_valid !== 1'b0) $display("FAIL full_req_valid: got %0b want 0", IFreq_valid); else pass_cnt++;
        chk_cnt++; if (IFinstr_valid !== 1'b1) $display("FAIL full_instr_valid: got %0b want 1", IFinstr_valid); else pass_cnt++;
        chk_cnt++; if (IFpc !== 32'h0) $display("FAIL full_head_pc: got %h want 0", IFpc); else pass_cnt++;
        IFinstr_ready = 1'b1;
        chk_cnt++; if (IFreq_valid !== 1'b0) $display("FAIL full_pop_cycle_valid: got %0b want 0", IFreq_valid); else pass_cnt++;
        tick();
        chk_cnt++; if (IFreq_valid !== 1'b1) $display("FAIL full_resume_valid: got %0b want 1", IFreq_valid); else pass_cnt++;
        chk_cnt++; if (IFreq_addr !== 32'h10) $display("FAIL full_resume_addr: got %h want 10", IFreq_addr); else pass_cnt++;
        chk_cnt++; if (IFinstr_valid !== 1'b1 || IFpc !== 32'h4) $display("FAIL full_next_head: got %0b/%h want 1/4", IFinstr_valid, IFpc); else pass_cnt++;
    endtask

    task automatic test_redirect_drain();
        do_reset();
        mem_en = 1'b0; IFreq_ready = 1'b1; IFinstr_ready = 1'b1;
        tick();
        tick();
        IFreq_ready = 1'b0; IFredirect = 1'b1; IFredirect_pc = 32'h103;
        tick();
        IFredirect = 1'b0; mem_en = 1'b1; IFreq_ready = 1'b1;
        chk_cnt++; if (IFinstr_valid !== 1'b0) $display("FAIL drain_queue_empty: got %0b want 0", IFinstr_valid); else pass_cnt++;
        chk_cnt++; if (IFreq_valid !== 1'b0) $display("FAIL drain_d0_valid: got %0b want 0", IFreq_valid); else pass_cnt++;
        tick();
        chk_cnt++; if (IFreq_valid !== 1'b0) $display("FAIL drain_d1_valid: got %0b want 0", IFreq_valid); else pass_cnt++;
        tick();
        chk_cnt++; if (IFreq_valid !== 1'b0) $display("FAIL drain_d2_valid: got %0b want 0", IFreq_valid); else pass_cnt++;
        tick();
        chk_cnt++; if (IFreq_valid !== 1'b1) $display("FAIL drain_refetch_valid: got %0b want 1", IFreq_valid); else pass_cnt++;
        chk_cnt++; if (IFreq_addr !== 32'h100) $display("FAIL drain_refetch_addr: got %h want 100", IFreq_addr); else pass_cnt++;
        chk_cnt++; if (IFinstr_valid !== 1'b0) $display("FAIL drain_dropped: got %0b want 0", IFinstr_valid); else pass_cnt++;
        tick();
        tick();
        tick();
        chk_cnt++; if (got_pc.size() !== 1) $display("FAIL drain_pops: got %0d want 1", got_pc.size()); else pass_cnt++;
        if (got_pc.size() > 0) begin
            chk_cnt++; if (got_pc[0] !== 32'h100 || got_ins[0] !== 32'h40) $display("FAIL drain_first: got %h/%h want 100/40", got_pc[0], got_ins[0]); else pass_cnt++;
        end
    endtask

    task automatic test_redirect_pop_rsp();
        do_reset();
        mem_en = 1'b1; IFreq_ready = 1'b1; IFinstr_ready = 1'b1;
        tick();
        tick();
        tick();
        chk_cnt++; if (IFinstr_valid !== 1'b1 || IFpc !== 32'h4 || IFrsp_valid !== 1'b1) $display("FAIL rpr_setup: got %0b/%h/%0b want 1/4/1", IFinstr_valid, IFpc, IFrsp_valid); else pass_cnt++;
        IFredirect = 1'b1; IFredirect_pc = 32'h200;
        tick();
        IFredirect = 1'b0;
        chk_cnt++; if (IFinstr_valid !== 1'b0) $display("FAIL rpr_flushed: got %0b want 0", IFinstr_valid); else pass_cnt++;
        chk_cnt++; if (IFreq_valid !== 1'b0) $display("FAIL rpr_drain_valid: got %0b want 0", IFreq_valid); else pass_cnt++;
        tick();
        chk_cnt++; if (IFreq_valid !== 1'b1 || IFreq_addr !== 32'h200) $display("FAIL rpr_refetch: got %0b/%h want 1/200", IFreq_valid, IFreq_addr); else pass_cnt++;
        tick();
        tick();
        tick();
        chk_cnt++; if (got_pc.size() !== 2) $display("FAIL rpr_pops: got %0d want 2", got_pc.size()); else pass_cnt++;
        if (got_pc.size() >= 2) begin
            chk_cnt++; if (got_pc[1] !== 32'h200 || got_ins[1] !== 32'h80) $display("FAIL rpr_target: got %h/%h want 200/80", got_pc[1], got_ins[1]); else pass_cnt++;
        end
    endtask

    task automatic test_stall();
        do_reset();
        mem_en = 1'b1; IFreq_ready = 1'b0; IFinstr_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk_cnt++; if (IFreq_valid !== 1'b1 || IFreq_addr !== 32'h0) $display("FAIL stall_hold%0d: got %0b/%h want 1/0", i, IFreq_valid, IFreq_addr); else pass_cnt++;
            tick();
        end
        IFreq_ready = 1'b1;
        tick();
        chk_cnt++; if (fire_addr.size() !== 1) $display("FAIL stall_fires: got %0d want 1", fire_addr.size()); else pass_cnt++;
        chk_cnt++; if (IFreq_addr !== 32'h4) $display("FAIL stall_next_addr: got %h want 4", IFreq_addr); else pass_cnt++;
        tick();
        tick();
        tick();
        chk_cnt++; if (got_pc.size() !== 2) $display("FAIL stall_pops: got %0d want 2", got_pc.size()); else pass_cnt++;
        if (got_pc.size() >= 2) begin
            chk_cnt++; if (got_pc[0] !== 32'h0 || got_pc[1] !== 32'h4) $display("FAIL stall_seq: got %h,%h want 0,4", got_pc[0], got_pc[1]); else pass_cnt++;
        end
    endtask

    task automatic test_wrap_and_reset();
        do_reset();
        mem_en = 1'b1; IFreq_ready = 1'b0; IFinstr_ready = 1'b1;
        IFredirect = 1'b1; IFredirect_pc = 32'hFFFF_FFFC;
        tick();
        IFredirect = 1'b0; IFreq_ready = 1'b1;
        chk_cnt++; if (IFreq_valid !== 1'b1 || IFreq_addr !== 32'hFFFF_FFFC) $display("FAIL wrap_top: got %0b/%h want 1/fffffffc", IFreq_valid, IFreq_addr); else pass_cnt++;
        tick();
        chk_cnt++; if (IFreq_addr !== 32'h0) $display("FAIL wrap_zero: got %h want 0", IFreq_addr); else pass_cnt++;
        tick();
        tick();
        chk_cnt++; if (got_pc.size() !== 1) $display("FAIL wrap_pops: got %0d want 1", got_pc.size()); else pass_cnt++;
        if (got_pc.size() > 0) begin
            chk_cnt++; if (got_pc[0] !== 32'hFFFF_FFFC || got_ins[0] !== 32'h3FFF_FFFF) $display("FAIL wrap_head: got %h/%h want fffffffc/3fffffff", got_pc[0], got_ins[0]); else pass_cnt++;
        end
        IFinstr_ready = 1'b0;
        reset = 1'b1;
        tick();
        chk_cnt++; if (IFinstr_valid !== 1'b0) $display("FAIL midreset_instr_valid: got %0b want 0", IFinstr_valid); else pass_cnt++;
        chk_cnt++; if (IFreq_valid !== 1'b0 || IFreq_addr !== 32'h0) $display("FAIL midreset_req: got %0b/%h want 0/0", IFreq_valid, IFreq_addr); else pass_cnt++;
        reset = 1'b0; IFreq_ready = 1'b0;
        got_pc.delete(); got_ins.delete();
        tick();
        tick();
        chk_cnt++; if (IFinstr_valid !== 1'b0) $display("FAIL midreset_stale: got %0b want 0", IFinstr_valid); else pass_cnt++;
        chk_cnt++; if (IFreq_valid !== 1'b1 || IFreq_addr !== 32'h0) $display("FAIL midreset_refetch: got %0b/%h want 1/0", IFreq_valid, IFreq_addr); else pass_cnt++;
        IFreq_ready = 1'b1; IFinstr_ready = 1'b1;
        tick();
        IFreq_ready = 1'b0;
        tick();
        tick();
        chk_cnt++; if (got_pc.size() !== 1) $display("FAIL midreset_pops: got %0d want 1", got_pc.size()); else pass_cnt++;
        if (got_pc.size() > 0) begin
            chk_cnt++; if (got_pc[0] !== 32'h0 || got_ins[0] !== 32'h0) $display("FAIL midreset_first: got %h/%h want 0/0", got_pc[0], got_ins[0]); else pass_cnt++;
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_full();
        test_redirect_drain();
        test_redirect_pop_rsp();
        test_stall();
        test_wrap_and_reset();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule
